// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: opcodes, FSM states and bit positions shared by
// the PIO command decoder and anything that builds its words.
package pio_cmd_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_SET_ADDR = 3'd1,
        OP_WR_PIX   = 3'd2,
        OP_RD_PIX   = 3'd3,
        OP_START    = 3'd4,
        OP_CLR      = 3'd5,
        OP_BAD6     = 3'd6,
        OP_BAD7     = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXEC   = 3'd1,
        S_RDWAIT = 3'd2,
        S_RUN    = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    localparam int ST_ACK    = 31;
    localparam int ST_BUSY   = 30;
    localparam int ST_DONE   = 29;
    localparam int ST_ERR    = 28;

    localparam int CMD_TOG   = 31;
    localparam int CMD_OP_HI = 30;
    localparam int CMD_OP_LO = 28;

endpackage

// File: rtl/pio_cmd_decoder.sv
// pio_cmd_decoder: toggle-handshake PIO command decoder.
// Option: PIO_CMD_READBACK_EN enables RD_PIX and read data in status.
module pio_cmd_decoder
    import pio_cmd_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cmd_word,
    output logic [31:0]       status_word,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              eng_start,
    input  logic              eng_done
);

    state_t            state;
    opcode_t           op_q;
    opcode_t           op_in;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pay_q;
    logic              last_tog;
    logic              ack;
    logic              busy;
    logic              done;
    logic              err;

`ifdef PIO_CMD_READBACK_EN
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    logic [CNT_W-1:0]  rd_cnt;
    logic [DATA_W-1:0] rdata;
    logic              unused_in;

    assign unused_in = &{1'b0, cmd_word[27:ADDR_W]};
`else
    logic              unused_in;

    assign unused_in = &{1'b0, cmd_word[27:ADDR_W], mem_rdata};
    assign mem_re    = 1'b0;
`endif

    assign op_in = opcode_t'(cmd_word[CMD_OP_HI:CMD_OP_LO]);

    // Status word is pure wiring of registered flags.
    always_comb begin
        status_word          = '0;
        status_word[ST_ACK]  = ack;
        status_word[ST_BUSY] = busy;
        status_word[ST_DONE] = done;
        status_word[ST_ERR]  = err;
`ifdef PIO_CMD_READBACK_EN
        status_word[DATA_W-1:0] = rdata;
`endif
    end

    // Command FSM: detect toggle, execute, wait, acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            addr      <= '0;
            pay_q     <= '0;
            last_tog  <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            eng_start <= 1'b0;
`ifdef PIO_CMD_READBACK_EN
            mem_re    <= 1'b0;
            rd_cnt    <= '0;
            rdata     <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            eng_start <= 1'b0;
`ifdef PIO_CMD_READBACK_EN
            mem_re    <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (cmd_word[CMD_TOG] != last_tog) begin
                        last_tog  <= cmd_word[CMD_TOG];
                        op_q      <= op_in;
                        pay_q     <= cmd_word[ADDR_W-1:0];
                        mem_addr  <= addr;
                        mem_wdata <= cmd_word[DATA_W-1:0];
                        state     <= S_EXEC;
                        // Strobes are registered so they are high in EXEC.
                        unique case (op_in)
                            OP_WR_PIX: mem_we <= 1'b1;
`ifdef PIO_CMD_READBACK_EN
                            OP_RD_PIX: mem_re <= 1'b1;
`endif
                            OP_START: begin
                                eng_start <= 1'b1;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    state <= S_ACK;
                    unique case (op_q)
                        OP_NOP:      ;
                        OP_SET_ADDR: addr <= pay_q;
                        OP_WR_PIX:   addr <= addr + ADDR_W'(1);
`ifdef PIO_CMD_READBACK_EN
                        OP_RD_PIX: begin
                            addr   <= addr + ADDR_W'(1);
                            rd_cnt <= '0;
                            state  <= S_RDWAIT;
                        end
`endif
                        OP_START:    state <= S_RUN;
                        OP_CLR: begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end
                        default:     err <= 1'b1;
                    endcase
                end
`ifdef PIO_CMD_READBACK_EN
                S_RDWAIT: begin
                    if (rd_cnt == CNT_W'(RD_LAT - 1)) begin
                        rdata <= mem_rdata;
                        state <= S_ACK;
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
`endif
                S_RUN: begin
                    if (eng_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack   <= last_tog;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_cmd_decoder.sv
// tb_pio_cmd_decoder: randomized bench with a transaction-level
// model of the PIO command protocol and a behavioural image memory.
module tb_pio_cmd_decoder;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       cmd_word = '0;
    logic [31:0]       status_word;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              eng_start;
    logic              eng_done = 1'b0;

    always #5 clk = ~clk;

    pio_cmd_decoder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_word   (cmd_word),
        .status_word(status_word),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .eng_start  (eng_start),
        .eng_done   (eng_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_pix(input int a);
        logic [31:0] v;
        v = a ^ (a >> 8) ^ 32'h5A;
        return v[7:0];
    endfunction

    // Image memory with RD_LAT-cycle read latency.
    logic [7:0] img [int];
    logic [7:0] rpipe [RD_LAT];
    int we_n = 0;
    int re_n = 0;
    int st_n = 0;
    int wr_a[$];
    int wr_d[$];
    int rd_a[$];

    always @(posedge clk) begin
        int a;
        a = int'(mem_addr);
        if (mem_we) begin
            img[a] = mem_wdata;
            we_n++;
            wr_a.push_back(a);
            wr_d.push_back(int'(mem_wdata));
        end
        if (mem_re) begin
            re_n++;
            rd_a.push_back(a);
        end
        if (eng_start) st_n++;
        rpipe[0] <= !mem_re ? 8'h00 :
                    (img.exists(a) ? img[a] : init_pix(a));
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign mem_rdata = rpipe[RD_LAT-1];

    // Reference model: protocol-level state.
    int         addr_m;
    bit         tog_m, ack_m, busy_m, done_m, err_m;
    logic [7:0] rdata_m;
    logic [7:0] mem_m [int];

    function automatic logic [7:0] model_rd(input int a);
        return mem_m.exists(a) ? mem_m[a] : init_pix(a);
    endfunction

    function automatic logic [31:0] exp_st();
        logic [31:0] s;
        s     = '0;
        s[31] = ack_m;
        s[30] = busy_m;
        s[29] = done_m;
        s[28] = err_m;
`ifdef PIO_CMD_READBACK_EN
        s[7:0] = rdata_m;
`endif
        return s;
    endfunction

    task automatic model_reset();
        addr_m  = 0;
        tog_m   = 1'b0;
        ack_m   = 1'b0;
        busy_m  = 1'b0;
        done_m  = 1'b0;
        err_m   = 1'b0;
        rdata_m = 8'h00;
    endtask

    task automatic issue(input int op, input logic [27:0] pay,
                         input int hold);
        int we0, re0, st0, ea, lat;
        bit old_ack;
        we0 = we_n;
        re0 = re_n;
        st0 = st_n;
        ea  = addr_m;
        wr_a.delete();
        wr_d.delete();
        rd_a.delete();
        old_ack = ack_m;
        tog_m   = ~tog_m;
        @(posedge clk);
        #1;
        cmd_word = {tog_m, 3'(op), pay};
        if (op != 4 && $urandom_range(0, 3) == 0) eng_done = 1'b1;
        lat = 3;
        case (op)
            1: addr_m = int'(pay) & AMASK;
            2: begin
                mem_m[ea] = pay[7:0];
                addr_m = (ea + 1) & AMASK;
            end
            3: begin
`ifdef PIO_CMD_READBACK_EN
                rdata_m = model_rd(ea);
                addr_m  = (ea + 1) & AMASK;
                lat     = 3 + RD_LAT;
`else
                err_m = 1'b1;
`endif
            end
            5: begin
                done_m = 1'b0;
                err_m  = 1'b0;
            end
            6, 7: err_m = 1'b1;
            default: ;
        endcase
        if (op == 4) begin
            busy_m = 1'b1;
            @(posedge clk);
            #1;
            check("start_busy", status_word, exp_st());
            repeat (hold) @(posedge clk);
            #1;
            check("run_hold", status_word, exp_st());
            eng_done = 1'b1;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            busy_m = 1'b0;
            done_m = 1'b1;
            check("run_done", status_word, exp_st());
            @(posedge clk);
            #1;
        end else begin
            for (int i = 1; i <= lat; i++) begin
                @(posedge clk);
                #1;
                eng_done = 1'b0;
                if (i == lat - 1)
                    check("ack_early", 32'(status_word[31]),
                          32'(old_ack));
            end
        end
        ack_m = tog_m;
        check($sformatf("status_op%0d", op), status_word, exp_st());
        check("we_cnt", 32'(we_n - we0), 32'(op == 2));
        check("st_cnt", 32'(st_n - st0), 32'(op == 4));
`ifdef PIO_CMD_READBACK_EN
        check("re_cnt", 32'(re_n - re0), 32'(op == 3));
        if (op == 3)
            check("rd_addr", rd_a.size() > 0 ? rd_a[0] : -1, ea);
`else
        check("re_cnt", 32'(re_n - re0), 32'd0);
`endif
        if (op == 2) begin
            check("wr_addr", wr_a.size() > 0 ? wr_a[0] : -1, ea);
            check("wr_data", wr_d.size() > 0 ? wr_d[0] : -1,
                  32'(pay[7:0]));
        end
    endtask

    initial begin
        int         ops[10];
        int         op;
        logic [27:0] p;
        ops = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 6};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", status_word, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_status", status_word, 32'h0);
        check("idle_strobes", 32'(we_n + re_n + st_n), 32'd0);

        issue(1, 28'h0010, 0);
        issue(2, 28'h00AB, 0);
        issue(2, 28'h00CD, 0);
        issue(1, 28'h1FFFF, 0);
        issue(2, 28'h0012, 0);
        issue(2, 28'h0034, 0);
        check("wrap_addr", wr_a.size() > 0 ? wr_a[0] : -1, 32'd0);
        issue(1, 28'h0300, 0);
        issue(2, 28'h005C, 0);
        issue(1, 28'h0300, 0);
        issue(3, 28'h0000, 0);
        issue(4, 28'h0000, 100);
        issue(5, 28'h0000, 0);
        issue(7, 28'h0000, 0);
        issue(5, 28'h0000, 0);

        // Reset while the engine is running.
        tog_m = ~tog_m;
        @(posedge clk);
        #1;
        cmd_word = {tog_m, 3'd4, 28'h0};
        repeat (6) @(posedge clk);
        #1;
        check("run_busy", 32'(status_word[30]), 32'd1);
        cmd_word = '0;
        reset_n  = 1'b0;
        #1;
        check("rst_async", status_word, 32'h0);
        check("rst_strobe", {29'd0, mem_we, mem_re, eng_start}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        eng_done = 1'b1;
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done_ign", status_word, 32'h0);

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 9)];
            if (op == 6) op = $urandom_range(6, 7);
            p = 28'($urandom);
            if (op == 1 && $urandom_range(0, 1) == 1)
                p[16:0] = 17'h1FFFF - 17'($urandom_range(0, 3));
            issue(op, p, $urandom_range(1, 20));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pio_cmd_decoder.md
# pio_cmd_decoder

Consumes the 32-bit command word driven by the HPS-facing output PIO and turns it into pixel-memory writes and reads and filter-engine start pulses. Produces a 32-bit status word for the companion input PIO, so software runs a toggle-handshake protocol over two plain PIO registers. It sits between the output PIO and the image buffer / filter engine, in the single fabric clock domain.

## Interface
- `ADDR_W`, 17: pixel address width (320×240 image).
- `DATA_W`, 8: pixel width.
- `RD_LAT`, 2: image-memory read latency in cycles (≥1).
- `clk` in 1: fabric clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cmd_word` in 32: command from the output PIO `out_port`. Held stable between software writes.
- `status_word` out 32: to the input PIO `in_port`.
- `mem_addr` out ADDR_W: image-memory address.
- `mem_wdata` out DATA_W: write data.
- `mem_we` out 1: write strobe, one cycle.
- `mem_re` out 1: read strobe, one cycle.
- `mem_rdata` in DATA_W: valid RD_LAT cycles after `mem_re`.
- `eng_start` out 1: one-cycle start pulse to the filter engine.
- `eng_done` in 1: one-cycle completion pulse from the engine.

## Operation
- Command fields:
  - [31] `tog`: new command when it differs from the last accepted `tog`.
  - [30:28] opcode.
  - [ADDR_W-1:0] or [DATA_W-1:0] payload.
- Opcodes:
  - 0 NOP.
  - 1 SET_ADDR: `addr` ← payload.
  - 2 WR_PIX: write payload[7:0] at `addr`, then `addr`+1.
  - 3 RD_PIX: read at `addr`, latch the data, then `addr`+1.
  - 4 START: pulse `eng_start` and set busy.
  - 5 CLR: clear done and err.
  - 6–7: set err.
- Status word:
  - [31] `ack`: equals `tog` of the last completed command.
  - [30] busy.
  - [29] done.
  - [28] err.
  - [DATA_W-1:0] last read data.
  - All other bits 0.
- FSM states:
  - IDLE: `tog`≠`last_tog` moves to EXEC and captures the word; `last_tog` updates here.
  - EXEC: one cycle. Issues `mem_we`, `mem_re` or `eng_start`.
    - RD_PIX goes to RDWAIT.
    - START goes to RUN.
    - All others go to ACK.
  - RDWAIT: counts RD_LAT cycles, latches `mem_rdata`, then goes to ACK.
  - RUN: waits for `eng_done`, which sets done and clears busy; then goes to ACK.
  - ACK: `ack` ← captured `tog`, then back to IDLE.
- Commands arriving while not in IDLE are not lost. `tog` is compared again on return to IDLE, and only the latest word is executed. Software must poll `ack` before writing again.
- Address increment wraps from 2^ADDR_W−1 to 0.
- START issued while busy is impossible by protocol, since RUN blocks.
- `eng_done` seen outside RUN is ignored.
- Reset (asynchronous, any state):
  - Returns to IDLE with `addr`=0, `last_tog`=0, `ack`=0, busy/done/err=0, read data=0.
  - All strobes are 0.
  - An in-flight engine run is abandoned; its later `eng_done` is ignored.

## Timing
- Detect to EXEC: 1 cycle after `cmd_word` changes.
- `ack` flips:
  - 3 cycles after `tog` changes for NOP/SET/WR/CLR/bad opcode.
  - 3+RD_LAT cycles for RD_PIX.
  - For START: `eng_done` cycle + 2.
- `mem_we`, `mem_re` and `eng_start` are asserted exactly one cycle, registered, in EXEC.
- All outputs are registered.

## Configuration
- `PIO_CMD_READBACK_EN` defined: RD_PIX is implemented, RDWAIT exists, and status[DATA_W-1:0] carries the read data.
- Not defined:
  - Opcode 3 sets err and is acked like a bad opcode.
  - `mem_re` is tied 0.
  - status[DATA_W-1:0] reads 0.

## Structure
- Shared package `pio_cmd_pkg`:
  - Opcode enum.
  - FSM state enum.
  - Status bit-position constants (`ST_ACK`=31, `ST_BUSY`=30, `ST_DONE`=29, `ST_ERR`=28).
  - Field positions (`CMD_TOG`=31, `CMD_OP` [30:28]).
- No sub-module. The RDWAIT latency counter is inline.

## Test plan
- Reset, then `cmd_word`=0: `status_word`=0, no strobes, stays in IDLE.
- SET_ADDR 0x00010 (tog=1), then WR_PIX 0xAB (tog=0): `mem_we` with `mem_addr`=0x10 and `mem_wdata`=0xAB; `ack`=0 three cycles after the second write; internal `addr`=0x11.
- Write 0x12 at 0x1FFFF, then WR_PIX 0x34 again: second write hits address 0 (wrap).
- RD_PIX with RD_LAT=2 and memory returning 0x5C (macro on): `ack` flips 5 cycles after `tog`, status[7:0]=0x5C. Macro off: err=1 and `mem_re` never asserted.
- START, `eng_done` held off for 100 cycles: busy=1 and `ack` unchanged; on `eng_done`, done=1, busy=0 and `ack` flips 2 cycles later. Then CLR gives done=0.
- Opcode 7 gives err=1 with `ack` flipping. Asserting `reset_n` low while in RUN clears all status bits immediately, and a later `eng_done` has no effect.
